bus_power_trim_sequencer: RTL
=============================

Name: bus_power_trim_sequencer

Overview:
- Controller that powers the CAN buses one at a time after a start request.
- For each bus it waits a settle time, then optionally runs an oscillator-trim handshake with a timeout.
- When every bus is done it signals completion.
- Sits in mopshub_top between the init FSM and the per-bus power switches / trim engine; drives power_bus_en, power_bus_cnt, start_trim_ack, end_trim_bus and end_power_init.

Parameters:
- MAX_BUSES, 16, number of physical buses; sets the width of power_mask and trim_fail.
- SETTLE_CYC, 16'd400, clk cycles spent in SETTLE per bus; legal range 1..65535.
- TRIM_TIMEOUT, 16'd4000, maximum clk cycles spent in TRIM_WAIT per bus; legal range 1..65535.

Ports:
- clk  in  1  system clock (40 MHz).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  sequence request; level sampled only in IDLE.
- n_buses  in  5  number of buses to power; 0 is treated as 1; values above MAX_BUSES are clamped to MAX_BUSES.
- osc_auto_trim  in  1  enables the trim phase; latched at start.
- trim_done  in  1  trim engine completion; sampled only in TRIM_WAIT.
- power_bus_en  out  1  high for the single POWER_ON cycle of the current bus.
- power_bus_cnt  out  5  index of the bus being processed.
- power_mask  out  MAX_BUSES  bit i set once bus i has been powered.
- start_trim_ack  out  1  one-cycle trim request (the TRIM_REQ cycle).
- end_trim_bus  out  1  one-cycle pulse after a successful trim (the NEXT cycle).
- trim_fail  out  MAX_BUSES  sticky; bit i set if bus i timed out in trim.
- end_power_init  out  1  one-cycle pulse (the DONE cycle).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset and clocking:
  - All outputs and the state register are 0 on rst, asynchronously; state becomes IDLE.
  - Reset in mid-sequence de-powers all buses immediately: power_mask is cleared.
  - Outputs are Moore-decoded from registered state and registered counters.
- States: IDLE, POWER_ON, SETTLE, TRIM_REQ, TRIM_WAIT, NEXT, DONE.
- IDLE:
  - When start=1 at a clk edge: latch n_eff = clamp(n_buses,1,MAX_BUSES) and trim_en = osc_auto_trim.
  - Clear cnt, power_mask and trim_fail; go to POWER_ON.
  - start in any other state is ignored. n_buses and osc_auto_trim changes after the start edge are ignored.
- POWER_ON (1 cycle):
  - power_bus_en=1; power_mask[cnt] is set at the exit edge.
  - Clear timer; go to SETTLE.
- SETTLE (exactly SETTLE_CYC cycles):
  - timer increments each cycle.
  - When timer==SETTLE_CYC-1, go to TRIM_REQ if trim_en, else NEXT.
- TRIM_REQ (1 cycle): start_trim_ack=1; clear timer; go to TRIM_WAIT.
- TRIM_WAIT:
  - trim_done=1 → record success, go to NEXT.
  - Otherwise, when timer==TRIM_TIMEOUT-1 → set trim_fail[cnt], go to NEXT.
  - If trim_done and timeout occur in the same cycle, success wins.
  - trim_done outside TRIM_WAIT has no effect.
- NEXT (1 cycle):
  - end_trim_bus=1 only if this bus trimmed successfully.
  - If cnt==n_eff-1 go to DONE; otherwise increment cnt and go to POWER_ON. cnt never wraps.
- DONE (1 cycle): end_power_init=1; go to IDLE.
- Retention: power_mask and trim_fail keep their values in IDLE until the next accepted start.
- power_bus_cnt equals cnt at all times.
- Latency, no trim: end_power_init is high in cycle n_eff*(SETTLE_CYC+2)+1 after the start edge.
- Latency, with trim: add (1+k) cycles per bus, where k is the TRIM_WAIT cycle count (k ≤ TRIM_TIMEOUT).

Test Plan:
- SETTLE_CYC=4, n_buses=2, osc_auto_trim=0, start pulse at edge 0 →
  - power_bus_en high in cycles 1 and 7; power_bus_cnt 0 then 1;
  - end_power_init high only in cycle 13; power_mask=16'h0003; start_trim_ack never asserted.
- SETTLE_CYC=4, n_buses=1, osc_auto_trim=1, trim_done asserted in the 3rd TRIM_WAIT cycle →
  - start_trim_ack in cycle 6; end_trim_bus in cycle 10; end_power_init in cycle 11; trim_fail=0.
- TRIM_TIMEOUT=8, n_buses=2, trim_done never asserted →
  - trim_fail=16'h0003; end_trim_bus never asserted; end_power_init still occurs.
- Boundary inputs and timing:
  - n_buses=0 → exactly one bus powered, power_mask=16'h0001.
  - n_buses=5'd31 → 16 buses powered, power_mask=16'hFFFF, power_bus_cnt ends at 15.
  - trim_done coincident with the timeout cycle → success (end_trim_bus=1, trim_fail bit clear).
- rst asserted mid-SETTLE of bus 1 →
  - all outputs 0 immediately, including power_mask=0 and busy=0.
  - A new start afterwards restarts from bus 0.
- Second start held high while busy → ignored; after DONE, a still-high start in IDLE relaunches the sequence with power_mask cleared.

Source files
------------

// File: rtl/bus_power_trim_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bus_power_trim_sequencer
// Purpose  : Powers the CAN buses one at a time after a start request. Each
//            bus gets a one-cycle power enable, then a fixed settle time, then
//            an optional oscillator-trim handshake bounded by a timeout. A
//            one-cycle completion pulse follows the last bus.
// Ports    : clk, rst            - clock, async active-high reset
//            start               - sequence request, sampled only in IDLE
//            n_buses[4:0]        - buses to power (0 -> 1, clamped to MAX_BUSES)
//            osc_auto_trim       - enables the trim phase, latched at start
//            trim_done           - trim engine completion, used only in TRIM_WAIT
//            power_bus_en        - high in the POWER_ON cycle of a bus
//            power_bus_cnt[4:0]  - index of the bus being processed
//            power_mask          - bit i set once bus i has been powered
//            start_trim_ack      - one-cycle trim request
//            end_trim_bus        - one-cycle pulse after a successful trim
//            trim_fail           - sticky per-bus trim timeout flags
//            end_power_init      - one-cycle completion pulse
//            busy                - high in every state except IDLE
// Revision : 1.0 - initial release
// ============================================================================
module bus_power_trim_sequencer #(
  parameter int          MAX_BUSES    = 16,
  parameter logic [15:0] SETTLE_CYC   = 16'd400,
  parameter logic [15:0] TRIM_TIMEOUT = 16'd4000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4:0]           n_buses,
  input  logic                 osc_auto_trim,
  input  logic                 trim_done,
  output logic                 power_bus_en,
  output logic [4:0]           power_bus_cnt,
  output logic [MAX_BUSES-1:0] power_mask,
  output logic                 start_trim_ack,
  output logic                 end_trim_bus,
  output logic [MAX_BUSES-1:0] trim_fail,
  output logic                 end_power_init,
  output logic                 busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_POWER_ON  = 3'd1;
  localparam logic [2:0] S_SETTLE    = 3'd2;
  localparam logic [2:0] S_TRIM_REQ  = 3'd3;
  localparam logic [2:0] S_TRIM_WAIT = 3'd4;
  localparam logic [2:0] S_NEXT      = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  localparam logic [4:0]           c_MAX_N = 5'(MAX_BUSES);
  localparam logic [MAX_BUSES-1:0] c_ONE   = {{(MAX_BUSES-1){1'b0}}, 1'b1};

  logic [2:0]           r_state;
  logic [4:0]           r_cnt;
  logic [4:0]           r_last;      // index of the final bus (n_eff - 1)
  logic [15:0]          r_timer;
  logic                 r_trim_en;
  logic                 r_trim_ok;   // current bus finished trim successfully
  logic [MAX_BUSES-1:0] r_power_mask;
  logic [MAX_BUSES-1:0] r_trim_fail;
  logic [4:0]           w_last;

  // Clamp the requested bus count to 1..MAX_BUSES and keep it as a last index.
  always_comb begin
    w_last = 5'd0;
    if (n_buses == 5'd0) begin
      w_last = 5'd0;
    end else if (n_buses > c_MAX_N) begin
      w_last = c_MAX_N - 5'd1;
    end else begin
      w_last = n_buses - 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 5'd0;
      r_last       <= 5'd0;
      r_timer      <= 16'd0;
      r_trim_en    <= 1'b0;
      r_trim_ok    <= 1'b0;
      r_power_mask <= '0;
      r_trim_fail  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_last       <= w_last;
            r_trim_en    <= osc_auto_trim;
            r_cnt        <= 5'd0;
            r_power_mask <= '0;
            r_trim_fail  <= '0;
            r_state      <= S_POWER_ON;
          end
        end
        S_POWER_ON: begin
          r_power_mask <= r_power_mask | (c_ONE << r_cnt);
          r_timer      <= 16'd0;
          r_trim_ok    <= 1'b0;
          r_state      <= S_SETTLE;
        end
        S_SETTLE: begin
          r_timer <= r_timer + 16'd1;
          if (r_timer == SETTLE_CYC - 16'd1) begin
            r_state <= r_trim_en ? S_TRIM_REQ : S_NEXT;
          end
        end
        S_TRIM_REQ: begin
          r_timer <= 16'd0;
          r_state <= S_TRIM_WAIT;
        end
        S_TRIM_WAIT: begin
          r_timer <= r_timer + 16'd1;
          // Completion is checked first so a coincident timeout still counts
          // as a successful trim.
          if (trim_done) begin
            r_trim_ok <= 1'b1;
            r_state   <= S_NEXT;
          end else if (r_timer == TRIM_TIMEOUT - 16'd1) begin
            r_trim_fail <= r_trim_fail | (c_ONE << r_cnt);
            r_state     <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_cnt == r_last) begin
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + 5'd1;
            r_state <= S_POWER_ON;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign power_bus_en   = (r_state == S_POWER_ON);
  assign power_bus_cnt  = r_cnt;
  assign power_mask     = r_power_mask;
  assign start_trim_ack = (r_state == S_TRIM_REQ);
  assign end_trim_bus   = (r_state == S_NEXT) && r_trim_ok;
  assign trim_fail      = r_trim_fail;
  assign end_power_init = (r_state == S_DONE);
  assign busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire
